persiana_scheduler: RTL and testbench

Command scheduler in front of the blind controller (`FSM_Persiana`). It arbitrates position requests from debounced local wall buttons and a remote valid/ready command port, then drives the blind controller's one-hot `abierta`/`media`/`cerrada`/`automatico` inputs as registered levels. It supervises the motor outputs `subir`/`bajar` until the move completes. A motor that runs too long, or a conflicting up+down drive, latches a fault.

---
 rtl/persiana_scheduler.sv | 147 ++++++++++++++
 tb/tb_persiana_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/persiana_scheduler.sv
// Command scheduler for the blind controller: debounces wall buttons, arbitrates
// them against a remote valid/ready port, issues one-hot position levels and times the motor.
module persiana_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic Reloj,
  input  logic reset,
  input  logic raw,
  output logic lvl
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] CM1  = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // level rises on the same edge the counter reaches DEB_CYCLES; counter saturates there
  always_ff @(posedge Reloj) begin
    if (reset) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (!raw) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else begin
      if (cnt != CMAX) cnt <= cnt + 1'b1;
      if (cnt >= CM1)  lvl <= 1'b1;
    end
  end
endmodule

module persiana_scheduler #(
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic       Reloj,
  input  logic       reset,
  input  logic [2:0] btn,
  input  logic       rem_valid,
  input  logic [1:0] rem_cmd,
  output logic       rem_ready,
  input  logic       subir,
  input  logic       bajar,
  output logic       abierta,
  output logic       media,
  output logic       cerrada,
  output logic       automatico,
  output logic       busy,
  output logic       fault
);
  localparam int NB = 3;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, MOVING, FAULT} state_t;
  typedef struct packed {
    logic       vld;
    logic [1:0] cmd;
  } req_t;

  state_t        state, nxt;
  logic [NB-1:0] deb, deb_q, rise;
  req_t          loc, pend;
  logic [1:0]    cmd;
  logic [3:0]    pos;
  logic [TW-1:0] timer;
  logic [1:0]    mcnt;
  logic          xfer, motor;

  persiana_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NB-1:0] (
    .Reloj(Reloj),
    .reset(reset),
    .raw  (btn),
    .lvl  (deb)
  );

  assign rise  = deb & ~deb_q;
  assign motor = subir | bajar;

  // lowest-numbered button wins a simultaneous rise
  always_comb begin
    loc.vld = |rise;
    loc.cmd = 2'd2;
    if (rise[1]) loc.cmd = 2'd1;
    if (rise[0]) loc.cmd = 2'd0;
  end

  assign rem_ready = (state == IDLE) && !loc.vld && !pend.vld;
  assign xfer      = rem_valid && rem_ready;

  always_ff @(posedge Reloj) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (pend.vld || xfer) nxt = ISSUE;
      ISSUE:   nxt = MOVING;
      MOVING: begin
        if (subir && bajar)                  nxt = FAULT;
        else if (timer == TMAX)              nxt = FAULT;
        else if (mcnt == 2'd2 && !motor)     nxt = IDLE;
      end
      default: nxt = FAULT;
    endcase
  end

  always_ff @(posedge Reloj) begin
    if (reset) begin
      deb_q <= '0;
      pend  <= '0;
      cmd   <= '0;
      pos   <= '0;
      timer <= '0;
      mcnt  <= '0;
    end else begin
      deb_q <= deb;
      if (nxt == FAULT)                 pend.vld <= 1'b0;
      else if (loc.vld)                 pend     <= loc;
      else if (state == IDLE && pend.vld) pend.vld <= 1'b0;

      if (state == IDLE) cmd <= pend.vld ? pend.cmd : rem_cmd;

      if (nxt == FAULT)         pos <= '0;
      else if (state == ISSUE)  pos <= 4'b0001 << cmd;

      if (state == ISSUE) begin
        timer <= '0;
        mcnt  <= '0;
      end else if (state == MOVING) begin
        // timing is per continuous motor run: an idle cycle restarts it
        if (!motor)              timer <= '0;
        else if (timer != TMAX)  timer <= timer + 1'b1;
        if (mcnt != 2'd2)        mcnt  <= mcnt + 1'b1;
      end
    end
  end

  assign abierta    = pos[0];
  assign media      = pos[1];
  assign cerrada    = pos[2];
  assign automatico = pos[3];
  assign busy       = (state == MOVING);
  assign fault      = (state == FAULT);
endmodule

// File: tb/tb_persiana_scheduler.sv
// Randomized scoreboard bench for persiana_scheduler: expected issued positions are
// queued by the stimulus and popped by a monitor whenever a new move starts.
module tb_persiana_scheduler;
  localparam int DEB = 4;
  localparam int TO  = 20;

  logic       Reloj = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] btn = 3'b000;
  logic       rem_valid = 1'b0;
  logic [1:0] rem_cmd = 2'b00;
  logic       subir = 1'b0, bajar = 1'b0;
  logic       rem_ready, abierta, media, cerrada, automatico, busy, fault;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic busy_prev = 1'b0;

  persiana_scheduler #(.DEB_CYCLES(DEB), .TIMEOUT(TO)) dut (
    .Reloj(Reloj), .reset(reset), .btn(btn), .rem_valid(rem_valid), .rem_cmd(rem_cmd),
    .rem_ready(rem_ready), .subir(subir), .bajar(bajar), .abierta(abierta), .media(media),
    .cerrada(cerrada), .automatico(automatico), .busy(busy), .fault(fault)
  );

  always #5 Reloj = ~Reloj;

  function automatic logic [3:0] onehot(input int c);
    logic [3:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic int lowbit(input logic [2:0] m);
    for (int i = 0; i < 3; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // monitor: every new move must present the next expected position
  always @(negedge Reloj) begin
    if (busy === 1'b1 && busy_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue actual=%0h expected=none",
                 {automatico, cerrada, media, abierta});
      end else begin
        chk("issued_position", {automatico, cerrada, media, abierta}, exp_q.pop_front());
      end
    end
    busy_prev = busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Reloj);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(busy == 1'b0 && rem_ready == 1'b1) && n < budget) begin tick(); n++; end
    if (n >= budget) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (busy != 1'b1 && n < budget) begin tick(); n++; end
    if (n >= budget) chk("wait_busy_timeout", 1, 0);
  endtask

  task automatic send_rem(input logic [1:0] c);
    int n = 0;
    rem_valid = 1'b1;
    rem_cmd   = c;
    while (!rem_ready && n < 200) begin tick(); n++; end
    if (n >= 200) chk("rem_handshake_timeout", 1, 0);
    exp_q.push_back(onehot(int'(c)));
    tick();
    rem_valid = 1'b0;
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    btn = m;
    repeat (hold) tick();
    btn = 3'b000;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("reset_pos", {automatico, cerrada, media, abierta}, 4'b0000);
    chk("reset_busy", busy, 0);
    chk("reset_fault", fault, 0);
    chk("reset_ready", rem_ready, 1);
    reset = 1'b0;
    tick();

    // remote closed: outputs one edge after transfer, busy for three cycles
    rem_valid = 1'b1;
    rem_cmd   = 2'b10;
    chk("idle_ready", rem_ready, 1);
    exp_q.push_back(4'b0100);
    tick();
    rem_valid = 1'b0;
    chk("cerrada_at_k", cerrada, 0);
    tick();
    chk("cerrada_at_k1", cerrada, 1);
    chk("busy_at_k1", busy, 1);
    n = 1;
    while (busy && n < 50) begin tick(); if (busy) n++; end
    chk("busy_cycles", n, 3);

    // short glitch produces nothing
    press(3'b001, DEB - 1);
    repeat (8) tick();
    chk("glitch_busy", busy, 0);
    chk("glitch_keep_cerrada", cerrada, 1);

    // local open held DEB cycles: output at edge DEB+3
    btn = 3'b001;
    exp_q.push_back(4'b0001);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 4) btn = 3'b000;
      if (e == 6) chk("abierta_edge6", abierta, 0);
      if (e == 7) chk("abierta_edge7", abierta, 1);
    end
    wait_idle(100);
    exp_q.push_back(4'b0010);
    press(3'b110, DEB);
    wait_idle(100);
    exp_q.push_back(4'b0001);
    press(3'b111, DEB);
    wait_idle(100);

    // local press during a move is pended and served before a stalled remote
    send_rem(2'b00);
    wait_busy(50);
    subir = 1'b1;
    exp_q.push_back(4'b0100);
    press(3'b100, DEB);
    rem_valid = 1'b1;
    rem_cmd   = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) chk("ready_stalled", rem_ready, 0);
    end
    subir = 1'b0;
    send_rem(2'b01);
    wait_idle(100);

    // randomized traffic with bounded motor runs
    for (int it = 0; it < 30; it++) begin
      int kind = $urandom_range(0, 2);
      if (kind == 0) begin
        send_rem(2'($urandom_range(0, 3)));
      end else if (kind == 1) begin
        logic [2:0] m = 3'($urandom_range(1, 7));
        exp_q.push_back(onehot(lowbit(m)));
        press(m, DEB + $urandom_range(0, 3));
      end else begin
        press(3'($urandom_range(1, 7)), $urandom_range(1, DEB - 1));
        repeat (3) tick();
      end
      if (kind != 2) begin
        int len = $urandom_range(0, 12);
        logic up = 1'($urandom_range(0, 1));
        wait_busy(60);
        if (up) subir = 1'b1; else bajar = (len != 0);
        if (len == 0) subir = 1'b0;
        repeat (len) tick();
        subir = 1'b0;
        bajar = 1'b0;
      end
      wait_idle(100);
      chk("random_no_fault", fault, 0);
    end

    // conflicting drive faults on the next edge
    send_rem(2'b01);
    wait_busy(50);
    subir = 1'b1;
    bajar = 1'b1;
    tick();
    chk("conflict_fault", fault, 1);
    chk("conflict_pos", {automatico, cerrada, media, abierta}, 4'b0000);
    subir = 1'b0;
    bajar = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("conflict_reset_fault", fault, 0);
    tick();

    // continuous run hits the timeout
    send_rem(2'b11);
    wait_busy(50);
    subir = 1'b1;
    repeat (TO) tick();
    chk("timeout_not_yet", fault, 0);
    chk("timeout_auto_held", automatico, 1);
    tick();
    chk("timeout_fault", fault, 1);
    chk("timeout_pos", {automatico, cerrada, media, abierta}, 4'b0000);
    chk("timeout_busy", busy, 0);
    rem_valid = 1'b1;
    rem_cmd   = 2'b00;
    btn       = 3'b001;
    repeat (DEB + 4) tick();
    chk("fault_ready", rem_ready, 0);
    chk("fault_ignores", abierta, 0);
    chk("fault_sticky", fault, 1);
    rem_valid = 1'b0;
    btn       = 3'b000;
    subir     = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("timeout_reset_fault", fault, 0);

    // reset mid-move
    send_rem(2'b10);
    wait_busy(50);
    subir = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("midmove_reset_pos", {automatico, cerrada, media, abierta}, 4'b0000);
    chk("midmove_reset_busy", busy, 0);
    subir = 1'b0;
    reset = 1'b0;
    tick();

    // automatic mode with short runs never faults
    send_rem(2'b11);
    wait_busy(50);
    for (int p = 0; p < 4; p++) begin
      subir = 1'b1;
      repeat (5) tick();
      subir = 1'b0;
      repeat (3) tick();
    end
    chk("auto_no_fault", fault, 0);
    chk("auto_level", automatico, 1);
    wait_idle(100);

    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
